// File: rtl/deintlv_pkg.sv
// rtl/deintlv_pkg.sv - shared constants and sizing helpers for the convolutional deinterleaver
// Purpose: default geometry (I=12 branches, M=17 unit delay) and the two
// sizing functions used to build the delay lines and the fill counter.
package deintlv_pkg;

  localparam int DEINTLV_I = 12;
  localparam int DEINTLV_M = 17;

  // Delay of branch j, in visits of that branch; the last branch is zero.
  function automatic int branch_delay(input int j, input int i, input int m);
    return (i - 1 - j) * m;
  endfunction

  // Accepted symbols needed before every branch outputs real data.
  function automatic int fill_len(input int i, input int m);
    return (i - 1) * m * i;
  endfunction

endpackage

// File: rtl/deintlv_delay_line.sv
// rtl/deintlv_delay_line.sv - reset-zeroed circular delay line for one deinterleaver branch
// Purpose: DEPTH-word FIFO of fixed occupancy. dout is the oldest word and is
// valid combinationally; on en the oldest word is replaced by din.
// Ports:
//   clk, reset : clock, synchronous active-high reset (zeroes every cell)
//   en         : shift one word in / out
//   din        : word written on en
//   dout       : oldest word, read before the write
module deintlv_delay_line #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  ptr_d;

  // The cell under the pointer is both the oldest word and the next write slot.
  assign dout  = mem_q[ptr_q];
  assign ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (en) begin
      mem_q[ptr_q] <= din;
      ptr_q        <= ptr_d;
    end
  end

endmodule

// File: rtl/conv_deinterleaver_param.sv
// rtl/conv_deinterleaver_param.sv - parametrised Forney convolutional deinterleaver
// Purpose: BRANCHES-branch deinterleaver; branch j delays by (BRANCHES-1-j)*DEPTH_M
// visits, the last branch passes straight through. Registered output stage,
// sync-driven commutator alignment and a primed (fill complete) flag.
// Optional build macro: DEINTLV_BYPASS_EN adds the bypass input.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   in_valid    : symbol accepted this cycle (no backpressure)
//   in_data     : input symbol
//   sync_in     : with in_valid, force this symbol onto branch 0
//   bypass      : (DEINTLV_BYPASS_EN only) route accepted symbols around the lines
//   out_valid   : output valid, one cycle after acceptance
//   out_data    : deinterleaved symbol, held while out_valid=0
//   out_branch  : branch index of out_data
//   primed      : every branch now outputs real data
module conv_deinterleaver_param
  import deintlv_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int BRANCHES = DEINTLV_I,
  parameter int DEPTH_M  = DEINTLV_M,
  parameter int SEL_W    = $clog2(BRANCHES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              sync_in,
`ifdef DEINTLV_BYPASS_EN
  input  logic              bypass,
`endif
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_branch,
  output logic              primed
);

  localparam int FILL   = fill_len(BRANCHES, DEPTH_M);
  localparam int FILL_W = $clog2(FILL + 1);

  logic bypass_w;
`ifdef DEINTLV_BYPASS_EN
  assign bypass_w = bypass;
`else
  assign bypass_w = 1'b0;
`endif

  // Commutator: sync overrides the pointer for the current symbol only.
  logic [SEL_W-1:0] sel_q, sel_d, cur_sel;
  assign cur_sel = sync_in ? '0 : sel_q;
  assign sel_d   = (cur_sel == SEL_W'(BRANCHES - 1)) ? '0 : cur_sel + SEL_W'(1);

  // Per-branch read words; the last branch reads the live input.
  logic [DATA_W-1:0] line_rd [BRANCHES];
  logic              line_en [BRANCHES-1];

  for (genvar j = 0; j < BRANCHES - 1; j++) begin : g_line
    assign line_en[j] = in_valid & ~bypass_w & (cur_sel == SEL_W'(j));

    deintlv_delay_line #(
      .DATA_W (DATA_W),
      .DEPTH  (branch_delay(j, BRANCHES, DEPTH_M))
    ) u_line (
      .clk   (clk),
      .reset (reset),
      .en    (line_en[j]),
      .din   (in_data),
      .dout  (line_rd[j])
    );
  end
  assign line_rd[BRANCHES-1] = in_data;

  logic [DATA_W-1:0] rd_word;
  always_comb begin
    rd_word = in_data;
    for (int j = 0; j < BRANCHES; j++) begin
      if (cur_sel == SEL_W'(j)) begin
        rd_word = line_rd[j];
      end
    end
  end

  // Fill counter saturates at FILL; primed rises on the first symbol
  // accepted once the counter is full. Both freeze during bypass.
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              primed_q, primed_d;

  always_comb begin
    fill_d   = fill_q;
    primed_d = primed_q;
    if (in_valid && !bypass_w) begin
      if (fill_q == FILL_W'(FILL)) begin
        primed_d = 1'b1;
      end else begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_branch_q;

  assign out_data_d = bypass_w ? in_data : rd_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q        <= '0;
      fill_q       <= '0;
      primed_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_branch_q <= '0;
    end else begin
      out_valid_q <= in_valid;
      fill_q      <= fill_d;
      primed_q    <= primed_d;
      if (in_valid) begin
        sel_q        <= sel_d;
        out_data_q   <= out_data_d;
        out_branch_q <= cur_sel;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_branch = out_branch_q;
  assign primed     = primed_q;

endmodule

// File: tb/tb_conv_deinterleaver_param.sv
// tb/tb_conv_deinterleaver_param.sv - self-checking bench for conv_deinterleaver_param
module tb_conv_deinterleaver_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: I=3, M=2. Instance 1: defaults I=12, M=17.
  logic       s_reset = 1'b1, s_valid = 1'b0, s_sync = 1'b0, s_byp = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ov, s_pr;
  logic [7:0] s_od;
  logic [1:0] s_ob;

  logic       d_reset = 1'b1, d_valid = 1'b0, d_sync = 1'b0, d_byp = 1'b0;
  logic [7:0] d_data = '0;
  logic       d_ov, d_pr;
  logic [7:0] d_od;
  logic [3:0] d_ob;

  conv_deinterleaver_param #(.DATA_W(8), .BRANCHES(3), .DEPTH_M(2)) u_small (
    .clk(clk), .reset(s_reset), .in_valid(s_valid), .in_data(s_data), .sync_in(s_sync),
`ifdef DEINTLV_BYPASS_EN
    .bypass(s_byp),
`endif
    .out_valid(s_ov), .out_data(s_od), .out_branch(s_ob), .primed(s_pr)
  );

  conv_deinterleaver_param u_dflt (
    .clk(clk), .reset(d_reset), .in_valid(d_valid), .in_data(d_data), .sync_in(d_sync),
`ifdef DEINTLV_BYPASS_EN
    .bypass(d_byp),
`endif
    .out_valid(d_ov), .out_data(d_od), .out_branch(d_ob), .primed(d_pr)
  );

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: each branch keeps the full history of words written
  // to it; a visit returns the word written D visits earlier, else 0.
  int         sel_m [2];
  int         fill_m [2];
  int         visits [2][16];
  logic [7:0] hist [2][16][4096];

  bit         nx_v [2], cur_v [2], nx_p [2], cur_p [2], nx_r [2], cur_r [2];
  logic [7:0] nx_d [2], cur_d [2];
  int         nx_b [2], cur_b [2];

  task automatic model(input int k, input bit rst, input bit v, input logic [7:0] d,
                       input bit s, input bit byp);
    int bi, bm, j, dl;
    bi = (k == 0) ? 3 : 12;
    bm = (k == 0) ? 2 : 17;
    nx_r[k] = rst;
    if (rst) begin
      sel_m[k] = 0; fill_m[k] = 0;
      for (int b = 0; b < 16; b++) visits[k][b] = 0;
      nx_v[k] = 0; nx_d[k] = 0; nx_b[k] = 0; nx_p[k] = 0;
    end else if (v) begin
      j = s ? 0 : sel_m[k];
      sel_m[k] = (j == bi - 1) ? 0 : j + 1;
      nx_v[k] = 1;
      nx_b[k] = j;
      if (byp) begin
        nx_d[k] = d;
      end else begin
        dl = (bi - 1 - j) * bm;
        if (dl == 0) nx_d[k] = d;
        else if (visits[k][j] >= dl) nx_d[k] = hist[k][j][visits[k][j] - dl];
        else nx_d[k] = 0;
        hist[k][j][visits[k][j]] = d;
        visits[k][j]++;
        if (fill_m[k] == (bi - 1) * bm * bi) nx_p[k] = 1;
        else fill_m[k]++;
      end
    end else begin
      nx_v[k] = 0;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      cur_v[k] <= nx_v[k]; cur_d[k] <= nx_d[k]; cur_b[k] <= nx_b[k];
      cur_p[k] <= nx_p[k]; cur_r[k] <= nx_r[k];
    end
  end

  // DUT output captures indexed by output number since the last reset.
  logic [7:0] cap_d [2][4096];
  int         cap_b [2][4096];
  bit         cap_p [2][4096];
  int         cap_n [2];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("small out_valid", s_ov, cur_v[0]);
      chk("small out_data", s_od, cur_d[0]);
      if (cur_v[0]) chk("small out_branch", s_ob, cur_b[0]);
      chk("small primed", s_pr, cur_p[0]);
      chk("dflt out_valid", d_ov, cur_v[1]);
      chk("dflt out_data", d_od, cur_d[1]);
      if (cur_v[1]) chk("dflt out_branch", d_ob, cur_b[1]);
      chk("dflt primed", d_pr, cur_p[1]);
    end
    if (cur_r[0]) cap_n[0] = 0;
    else if (s_ov) begin
      cap_d[0][cap_n[0]] = s_od; cap_b[0][cap_n[0]] = s_ob; cap_p[0][cap_n[0]] = s_pr;
      cap_n[0] = (cap_n[0] + 1) & 4095;
    end
    if (cur_r[1]) cap_n[1] = 0;
    else if (d_ov) begin
      cap_d[1][cap_n[1]] = d_od; cap_b[1][cap_n[1]] = d_ob; cap_p[1][cap_n[1]] = d_pr;
      cap_n[1] = (cap_n[1] + 1) & 4095;
    end
  end

  task automatic step(input int k, input bit rst, input bit v, input logic [7:0] d,
                      input bit s, input bit byp);
    @(posedge clk); #1;
    if (k == 0) begin
      s_reset = rst; s_valid = v; s_data = d; s_sync = s; s_byp = byp;
      d_reset = 0; d_valid = 0; d_sync = 0; d_byp = 0;
    end else begin
      d_reset = rst; d_valid = v; d_data = d; d_sync = s; d_byp = byp;
      s_reset = 0; s_valid = 0; s_sync = 0; s_byp = 0;
    end
    model(0, s_reset, s_valid, s_data, s_sync, s_byp);
    model(1, d_reset, d_valid, d_data, d_sync, d_byp);
  endtask

  task automatic reset_all();
    @(posedge clk); #1;
    s_reset = 1; s_valid = 0; s_sync = 0; s_byp = 0;
    d_reset = 1; d_valid = 0; d_sync = 0; d_byp = 0;
    model(0, 1, 0, 0, 0, 0);
    model(1, 1, 0, 0, 0, 0);
  endtask

  task automatic idle2(input int k);
    step(k, 0, 0, 8'h00, 0, 0);
    step(k, 0, 0, 8'h00, 0, 0);
  endtask

  int lit_n [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 12, 13};
  int lit_v [11] = '{0, 0, 3, 0, 0, 6, 0, 2, 9, 1, 8};

  task automatic check_small(input string tag);
    for (int i = 0; i < 11; i++)
      chk($sformatf("%s out[%0d]", tag, lit_n[i]), cap_d[0][lit_n[i]], lit_v[i]);
    chk({tag, " primed n=11"}, cap_p[0][11], 0);
    chk({tag, " primed n=12"}, cap_p[0][12], 1);
  endtask

  logic [7:0] rin [64];

  initial begin
    reset_all();
    @(posedge clk); #1;
    chk_en = 1'b1;

    // I=3, M=2, consecutive symbols n+1
    reset_all();
    for (int n = 0; n < 21; n++) step(0, 0, 1, 8'(n + 1), 0, 0);
    idle2(0);
    check_small("contig");

    // Same stream with in_valid toggling
    reset_all();
    for (int n = 0; n < 21; n++) begin
      step(0, 0, 1, 8'(n + 1), 0, 0);
      step(0, 0, 0, 8'($urandom), 0, 0);
    end
    idle2(0);
    check_small("gapped");
    for (int n = 0; n < 21; n++) chk($sformatf("gapped branch[%0d]", n), cap_b[0][n], n % 3);

    // Defaults: priming boundary
    reset_all();
    for (int n = 0; n < 2257; n++) step(1, 0, 1, 8'(n), 0, 0);
    idle2(1);
    chk("dflt primed n=2243", cap_p[1][2243], 0);
    chk("dflt primed n=2244", cap_p[1][2244], 1);
    chk("dflt out n=2244", cap_d[1][2244], 0);
    chk("dflt out n=2255", cap_d[1][2255], 207);

    // sync_in: ignored without in_valid, forces branch 0 with it
    reset_all();
    for (int n = 0; n < 5; n++) step(1, 0, 1, 8'($urandom), 0, 0);
    step(1, 0, 0, 8'($urandom), 1, 0);
    step(1, 0, 1, 8'($urandom), 0, 0);
    step(1, 0, 1, 8'($urandom), 1, 0);
    step(1, 0, 1, 8'($urandom), 0, 0);
    idle2(1);
    chk("sync no-valid branch", cap_b[1][5], 5);
    chk("sync branch", cap_b[1][6], 0);
    chk("post-sync branch", cap_b[1][7], 1);

    // Reset mid-stream at n=100, then restart
    reset_all();
    for (int n = 0; n < 100; n++) step(1, 0, 1, 8'($urandom), 0, 0);
    step(1, 1, 1, 8'hA5, 0, 0);
    for (int n = 0; n < 16; n++) begin
      rin[n] = 8'($urandom);
      step(1, 0, 1, rin[n], 0, 0);
    end
    idle2(1);
    for (int n = 0; n < 11; n++) chk($sformatf("restart out[%0d]", n), cap_d[1][n], 0);
    chk("restart out[11]", cap_d[1][11], rin[11]);
    chk("restart primed", cap_p[1][11], 0);

    // Random valid/sync/data on both configurations
    reset_all();
    for (int n = 0; n < 600; n++)
      step(1, 0, ($urandom_range(3) != 0), 8'($urandom), ($urandom_range(15) == 0), 0);
    idle2(1);
    reset_all();
    for (int n = 0; n < 300; n++)
      step(0, 0, ($urandom_range(3) != 0), 8'($urandom), ($urandom_range(15) == 0), 0);
    idle2(0);

`ifdef DEINTLV_BYPASS_EN
    // Bypass five symbols mid-stream
    reset_all();
    for (int n = 0; n < 40; n++) begin
      rin[n] = 8'($urandom);
      step(0, 0, 1, rin[n], 0, (n >= 10 && n < 15));
    end
    idle2(0);
    for (int n = 10; n < 15; n++) chk($sformatf("bypass out[%0d]", n), cap_d[0][n], rin[n]);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
